// File: rtl/flags_pkg.sv
// flags_pkg: ALU op encoding and NZCV bit positions shared with the branch-condition checker.
package flags_pkg;
  typedef enum logic [1:0] {ADD = 2'b00, SUB = 2'b01, AND = 2'b10, ORR = 2'b11} aluop_t;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/flags_writer_if.sv
// flags_writer_if: EX operands, pipeline control and flag outputs of the NZCV producer.
interface flags_writer_if #(parameter int N = 64) ();
  import flags_pkg::*;
  logic         ex_valid;
  logic         ex_setflags;
  aluop_t       ex_aluop;
  logic [N-1:0] ex_a;
  logic [N-1:0] ex_b;
  logic         advance;
  logic         flush;
  logic [3:0]   cpsr_flags;
  logic         write_flags;
  logic [3:0]   fwd_flags;
  logic         fwd_valid;
  logic [1:0]   flags_pending;
  modport master (
    output ex_valid, ex_setflags, ex_aluop, ex_a, ex_b, advance, flush,
    input  cpsr_flags, write_flags, fwd_flags, fwd_valid, flags_pending
  );
  modport slave (
    input  ex_valid, ex_setflags, ex_aluop, ex_a, ex_b, advance, flush,
    output cpsr_flags, write_flags, fwd_flags, fwd_valid, flags_pending
  );
endinterface

// File: rtl/nzcv_calc.sv
// nzcv_calc: combinational NZCV from ALU operands; SUB is a + ~b + 1 so carry means a >= b.
module nzcv_calc import flags_pkg::*; #(
  parameter int N = 64
) (
  input  aluop_t       op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [3:0]   flags
);
  logic         sub;
  logic         arith;
  logic [N-1:0] bb;
  logic [N-1:0] r;
  logic [N:0]   sum;
  always_comb begin
    sub = op == SUB;
    arith = op == ADD || sub;
    bb = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, sub};
    r = op == AND ? a & b : op == ORR ? a | b : sum[N-1:0];
    flags = '0;
    flags[FLAG_Z] = r == '0;
    flags[FLAG_N] = r[N-1];
    flags[FLAG_C] = arith && sum[N];
    flags[FLAG_V] = arith && (a[N-1] == bb[N-1]) && (r[N-1] != a[N-1]);
  end
endmodule

// File: rtl/flags_writer.sv
// flags_writer: carries flag-setter results EX->MEM->WB, commits NZCV at WB and bypasses the youngest.
module flags_writer import flags_pkg::*; #(
  parameter int N = 64
) (
  input logic           clk,
  input logic           reset,
  flags_writer_if.slave bus
);
  logic [3:0] ex_flags;
  logic       capture;
  logic       mem_valid_q, mem_valid_d, wb_valid_q, wb_valid_d, wr_q, wr_d;
  logic [3:0] mem_flags_q, mem_flags_d, wb_flags_q, wb_flags_d, cpsr_q, cpsr_d;

  nzcv_calc #(.N(N)) u_calc (
    .op    (bus.ex_aluop),
    .a     (bus.ex_a),
    .b     (bus.ex_b),
    .flags (ex_flags)
  );

  // flush kills EX and MEM only; WB is already past the branch and still commits
  always_comb begin
    capture = bus.advance && bus.ex_valid && bus.ex_setflags && !bus.flush;
    mem_valid_d = bus.advance ? capture : mem_valid_q && !bus.flush;
    mem_flags_d = capture ? ex_flags : mem_flags_q;
    wb_valid_d = bus.advance ? mem_valid_q && !bus.flush : wb_valid_q;
    wb_flags_d = bus.advance ? mem_flags_q : wb_flags_q;
    wr_d = bus.advance && wb_valid_q;
    cpsr_d = wr_d ? wb_flags_q : cpsr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid_q <= 1'b0;
      mem_flags_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_flags_q  <= '0;
      cpsr_q      <= '0;
      wr_q        <= 1'b0;
    end else begin
      mem_valid_q <= mem_valid_d;
      mem_flags_q <= mem_flags_d;
      wb_valid_q  <= wb_valid_d;
      wb_flags_q  <= wb_flags_d;
      cpsr_q      <= cpsr_d;
      wr_q        <= wr_d;
    end
  end

  assign bus.cpsr_flags    = cpsr_q;
  assign bus.write_flags   = wr_q;
  assign bus.fwd_flags     = mem_valid_q ? mem_flags_q : wb_valid_q ? wb_flags_q : cpsr_q;
  assign bus.fwd_valid     = mem_valid_q || wb_valid_q;
  assign bus.flags_pending = {1'b0, mem_valid_q} + {1'b0, wb_valid_q};
endmodule

// File: tb/tb_flags_writer.sv
// tb_flags_writer: directed and random checks of flags_writer against an age-tagged in-flight model.
module tb_flags_writer;
  import flags_pkg::*;
  localparam logic signed [65:0] MAXS = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] MINS = -66'sh0_8000_0000_0000_0000;
  typedef struct {logic [3:0] f; int age;} ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  flags_writer_if #(.N(64)) bus ();
  flags_writer #(.N(64)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  ent_t inflight[$];
  logic [3:0] m_cpsr = 4'b0000;
  logic m_wr = 1'b0;

  function automatic logic [3:0] ref_flags(aluop_t op, logic [63:0] a, logic [63:0] b);
    logic [63:0] r;
    logic c, v;
    logic signed [65:0] sa, sb, ss;
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    c = 1'b0;
    v = 1'b0;
    case (op)
      ADD: begin r = a + b; c = r < a; ss = sa + sb; v = ss > MAXS || ss < MINS; end
      SUB: begin r = a - b; c = a >= b; ss = sa - sb; v = ss > MAXS || ss < MINS; end
      AND: r = a & b;
      default: r = a | b;
    endcase
    return {r == 64'd0, r[63], c, v};
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return ~64'd0;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [3:0] ef;
    int best;
    ef = m_cpsr;
    best = 3;
    foreach (inflight[i]) if (inflight[i].age < best) begin best = inflight[i].age; ef = inflight[i].f; end
    chk({tag, ".cpsr"}, bus.cpsr_flags, m_cpsr);
    chk({tag, ".write"}, {3'b0, bus.write_flags}, {3'b0, m_wr});
    chk({tag, ".fwd"}, bus.fwd_flags, ef);
    chk({tag, ".fwd_valid"}, {3'b0, bus.fwd_valid}, {3'b0, inflight.size() != 0});
    chk({tag, ".pending"}, {2'b0, bus.flags_pending}, 4'(inflight.size()));
  endtask

  task automatic step(string tag, logic adv, logic fl, logic v, logic s, aluop_t op,
                      logic [63:0] a, logic [63:0] b);
    ent_t nq[$];
    bus.advance = adv;
    bus.flush = fl;
    bus.ex_valid = v;
    bus.ex_setflags = s;
    bus.ex_aluop = op;
    bus.ex_a = a;
    bus.ex_b = b;
    @(posedge clk);
    m_wr = 1'b0;
    if (adv) begin
      foreach (inflight[i])
        if (inflight[i].age == 2) begin m_cpsr = inflight[i].f; m_wr = 1'b1; end
        else if (!fl) nq.push_back('{inflight[i].f, 2});
      if (v && s && !fl) nq.push_back('{ref_flags(op, a, b), 1});
    end else begin
      foreach (inflight[i]) if (!(fl && inflight[i].age == 1)) nq.push_back(inflight[i]);
    end
    inflight = nq;
    #1 check_all(tag);
  endtask

  task automatic idle(string tag);
    step(tag, 1'b1, 1'b0, 1'b0, 1'b0, ADD, 64'd0, 64'd0);
  endtask

  task automatic do_reset(string tag);
    #2 reset = 1'b1;
    #1 inflight.delete();
    m_cpsr = 4'b0000;
    m_wr = 1'b0;
    check_all(tag);
    reset = 1'b0;
  endtask

  initial begin
    bus.advance = 1'b0;
    bus.flush = 1'b0;
    bus.ex_valid = 1'b0;
    bus.ex_setflags = 1'b0;
    bus.ex_aluop = ADD;
    bus.ex_a = '0;
    bus.ex_b = '0;
    repeat (2) @(posedge clk);
    #1 check_all("por");
    reset = 1'b0;

    step("subs55", 1'b1, 1'b0, 1'b1, 1'b1, SUB, 64'd5, 64'd5);
    idle("subs55.mem");
    idle("subs55.wb");
    chk("subs55.value", bus.cpsr_flags, 4'b1010);
    idle("subs55.after");

    step("adds_ovf", 1'b1, 1'b0, 1'b1, 1'b1, ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    idle("adds_ovf.1");
    idle("adds_ovf.2");
    chk("adds_ovf.value", bus.cpsr_flags, 4'b0101);
    step("adds_wrap", 1'b1, 1'b0, 1'b1, 1'b1, ADD, ~64'd0, 64'd1);
    idle("adds_wrap.1");
    idle("adds_wrap.2");
    chk("adds_wrap.value", bus.cpsr_flags, 4'b1010);
    step("subs01", 1'b1, 1'b0, 1'b1, 1'b1, SUB, 64'd0, 64'd1);
    idle("subs01.1");
    idle("subs01.2");
    chk("subs01.value", bus.cpsr_flags, 4'b0100);

    step("b2b.subs", 1'b1, 1'b0, 1'b1, 1'b1, SUB, 64'd3, 64'd5);
    chk("b2b.fwd_subs", bus.fwd_flags, 4'b0100);
    step("b2b.ands", 1'b1, 1'b0, 1'b1, 1'b1, AND, 64'd0, 64'h1234_5678_9ABC_DEF0);
    chk("b2b.fwd_ands", bus.fwd_flags, 4'b1000);
    chk("b2b.peak", {2'b0, bus.flags_pending}, 4'd2);
    idle("b2b.c1");
    idle("b2b.c2");
    chk("b2b.last", bus.cpsr_flags, 4'b1000);
    idle("b2b.end");

    step("fl.a", 1'b1, 1'b0, 1'b1, 1'b1, ADD, 64'd1, 64'd1);
    step("fl.b", 1'b1, 1'b0, 1'b1, 1'b1, SUB, 64'd1, 64'd2);
    step("fl.kill", 1'b1, 1'b1, 1'b1, 1'b1, ORR, ~64'd0, 64'd0);
    chk("fl.commit", bus.cpsr_flags, 4'b0000);
    chk("fl.drained", {2'b0, bus.flags_pending}, 4'd0);
    idle("fl.end");

    step("hold.a", 1'b1, 1'b0, 1'b1, 1'b1, SUB, 64'd2, 64'd1);
    idle("hold.wb");
    for (int i = 0; i < 3; i++) step("hold.stall", 1'b0, 1'b0, 1'b1, 1'b1, ADD, ~64'd0, ~64'd0);
    idle("hold.release");
    chk("hold.value", bus.cpsr_flags, 4'b0010);

    step("nos", 1'b1, 1'b0, 1'b1, 1'b0, SUB, 64'd0, 64'd0);
    idle("nos.1");
    idle("nos.2");

    step("rst.a", 1'b1, 1'b0, 1'b1, 1'b1, SUB, 64'd0, 64'd1);
    step("rst.b", 1'b1, 1'b0, 1'b1, 1'b1, ADD, 64'd0, 64'd0);
    do_reset("rst.mid");

    for (int i = 0; i < 400; i++) begin
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, aluop_t'($urandom_range(0, 3)), pick(), pick());
      if (i % 97 == 96) do_reset("rand.rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
